// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the N-way round-robin arbiter.
// Used by round_robin_arbiter_n and round_robin_pick.
package rr_arb_pkg;

  localparam int RR_HOLD_CNT_W = 8;
  localparam int RR_N_MIN      = 2;
  localparam int RR_N_MAX      = 32;
  localparam int RR_HOLD_MIN   = 1;
  localparam int RR_HOLD_MAX   = 255;

  // Modulo increment by explicit compare, so non-power-of-2 N wraps correctly.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic bit rr_n_ok(input int n);
    return (n >= RR_N_MIN) && (n <= RR_N_MAX);
  endfunction

  function automatic bit rr_hold_ok(input int h);
    return (h >= RR_HOLD_MIN) && (h <= RR_HOLD_MAX);
  endfunction

endpackage

// File: rtl/round_robin_arbiter_n_pick.sv
// Combinational rotating priority pick: first set req bit at or above ptr, wrapping.
// Double-width masked search; zero latency, no backpressure.
module round_robin_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Lower copy of req is masked below ptr; upper copy is unmasked to cover the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!valid && req[j % N] && ((j >= N) || (j >= int'(ptr)))) begin
        valid           = 1'b1;
        grant[j % N]    = 1'b1;
        idx             = IDX_W'(j % N);
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with ready handshake and bounded burst hold.
// Grant is combinational from req and state; an unaccepted grant is held stable.
module round_robin_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 1,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             ready,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             owned
);

  if (!rr_n_ok(N)) begin : g_bad_n
    $error("round_robin_arbiter_n: N=%0d outside 2..32", N);
  end
  if (!rr_hold_ok(MAX_HOLD)) begin : g_bad_hold
    $error("round_robin_arbiter_n: MAX_HOLD=%0d outside 1..255", MAX_HOLD);
  end

  logic [IDX_W-1:0]         ptr_r;
  logic                     own_v_r;
  logic [IDX_W-1:0]         own_idx_r;
  logic [RR_HOLD_CNT_W-1:0] hold_cnt_r;

  logic [N-1:0]             pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_valid;
  logic                     own_hit;
  logic [N-1:0]             own_oh;
  logic [IDX_W-1:0]         winner;
  logic                     accept;
  logic [RR_HOLD_CNT_W-1:0] base_cnt;
  logic [RR_HOLD_CNT_W:0]   cnt_next;

  round_robin_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_hit     = own_v_r & req[own_idx_r];
  assign own_oh      = {{(N-1){1'b0}}, 1'b1} << own_idx_r;
  assign grant       = own_hit ? own_oh : pick_grant;
  assign grant_valid = own_hit | pick_valid;
  assign winner      = own_hit ? own_idx_r : pick_idx;
  assign grant_idx   = grant_valid ? winner : '0;
  assign owned       = own_hit;
  assign accept      = grant_valid & ready;

  // A winner that took over from a withdrawn owner starts its own burst count.
  assign base_cnt = own_hit ? hold_cnt_r : '0;
  assign cnt_next = {1'b0, base_cnt} + (RR_HOLD_CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r      <= '0;
      own_v_r    <= 1'b0;
      own_idx_r  <= '0;
      hold_cnt_r <= '0;
    end else if (!grant_valid) begin
      own_v_r <= 1'b0;
    end else if (!accept) begin
      own_v_r    <= 1'b1;
      own_idx_r  <= winner;
      hold_cnt_r <= base_cnt;
    end else if (cnt_next < (RR_HOLD_CNT_W+1)'(MAX_HOLD)) begin
      own_v_r    <= 1'b1;
      own_idx_r  <= winner;
      hold_cnt_r <= cnt_next[RR_HOLD_CNT_W-1:0];
    end else begin
      own_v_r    <= 1'b0;
      hold_cnt_r <= '0;
      ptr_r      <= IDX_W'(rr_wrap_inc(int'(winner), N));
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed bench for round_robin_arbiter_n across several N / MAX_HOLD configurations.
module tb_round_robin_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: N=2 MH=1, b: N=4 MH=1, c: N=4 MH=3, d: N=3 MH=1, e: N=4 MH=4
  logic       rst_a, rst_b, rst_c, rst_d, rst_e;
  logic       rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic [1:0] req_a, gnt_a;
  logic [3:0] req_b, gnt_b, req_c, gnt_c, req_e, gnt_e;
  logic [2:0] req_d, gnt_d;
  logic       gv_a, gv_b, gv_c, gv_d, gv_e;
  logic [0:0] gi_a;
  logic [1:0] gi_b, gi_c, gi_d, gi_e;
  logic       own_a, own_b, own_c, own_d, own_e;

  round_robin_arbiter_n #(.N(2), .MAX_HOLD(1)) u_a (.clk(clk), .rst_n(rst_a), .req(req_a),
    .ready(rdy_a), .grant(gnt_a), .grant_valid(gv_a), .grant_idx(gi_a), .owned(own_a));
  round_robin_arbiter_n #(.N(4), .MAX_HOLD(1)) u_b (.clk(clk), .rst_n(rst_b), .req(req_b),
    .ready(rdy_b), .grant(gnt_b), .grant_valid(gv_b), .grant_idx(gi_b), .owned(own_b));
  round_robin_arbiter_n #(.N(4), .MAX_HOLD(3)) u_c (.clk(clk), .rst_n(rst_c), .req(req_c),
    .ready(rdy_c), .grant(gnt_c), .grant_valid(gv_c), .grant_idx(gi_c), .owned(own_c));
  round_robin_arbiter_n #(.N(3), .MAX_HOLD(1)) u_d (.clk(clk), .rst_n(rst_d), .req(req_d),
    .ready(rdy_d), .grant(gnt_d), .grant_valid(gv_d), .grant_idx(gi_d), .owned(own_d));
  round_robin_arbiter_n #(.N(4), .MAX_HOLD(4)) u_e (.clk(clk), .rst_n(rst_e), .req(req_e),
    .ready(rdy_e), .grant(gnt_e), .grant_valid(gv_e), .grant_idx(gi_e), .owned(own_e));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] t1_req [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
  logic [1:0] t1_gnt [10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
  int         t2_idx [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int         t2b_idx[3]  = '{1, 3, 1};
  int         t4_idx [7]  = '{0, 0, 0, 1, 1, 1, 0};
  int         t5_idx [8]  = '{0, 1, 2, 0, 1, 2, 0, 1};
  int         t6_idx [5]  = '{2, 2, 2, 2, 3};

  initial begin
    {rst_a, rst_b, rst_c, rst_d, rst_e} = '0;
    {rdy_a, rdy_b, rdy_c, rdy_d, rdy_e} = '1;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0; req_e = '0;
    #2;
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gv_a",  32'(gv_a),  0);
    chk("rst_gi_b",  32'(gi_b),  0);
    chk("rst_own_e", 32'(own_e), 0);
    chk("rst_gnt_e", 32'(gnt_e), 0);
    @(negedge clk);
    {rst_a, rst_b, rst_c, rst_d, rst_e} = '1;

    // N=2 sequence matching the 2-request arbiter
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); req_a = t1_req[i]; #2;
      chk($sformatf("t1_gnt[%0d]", i), 32'(gnt_a), 32'(t1_gnt[i]));
      chk($sformatf("t1_gv[%0d]", i),  32'(gv_a),  32'(|t1_gnt[i]));
    end

    // N=4 full rotation, then sparse requests
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req_b = 4'b1111; #2;
      chk($sformatf("t2_idx[%0d]", i), 32'(gi_b), 32'(t2_idx[i]));
      chk($sformatf("t2_gnt[%0d]", i), 32'(gnt_b), 32'(1) << t2_idx[i]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_b = 4'b1010; #2;
      chk($sformatf("t2b_idx[%0d]", i), 32'(gi_b), 32'(t2b_idx[i]));
    end

    // Stall: grant held while ready is low
    @(negedge clk); req_b = '0; rst_b = 1'b0; #1 rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req_b = 4'b0110; rdy_b = (i == 3); #2;
      chk($sformatf("t3_idx[%0d]", i), 32'(gi_b), 1);
      if (i > 0) chk($sformatf("t3_own[%0d]", i), 32'(own_b), 1);
    end
    @(negedge clk); rdy_b = 1'b1; #2;
    chk("t3_after", 32'(gi_b), 2);
    chk("t3_after_own", 32'(own_b), 0);

    // Bursts of 3, then owner withdraws mid-burst
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); req_c = 4'b0011; #2;
      chk($sformatf("t4_idx[%0d]", i), 32'(gi_c), 32'(t4_idx[i]));
    end
    @(negedge clk); req_c = 4'b0010; #2;
    chk("t4_drop_idx", 32'(gi_c), 1);
    chk("t4_drop_own", 32'(own_c), 0);
    @(negedge clk); req_c = 4'b0000; #2;
    chk("t4_idle_gv", 32'(gv_c), 0);
    chk("t4_idle_gi", 32'(gi_c), 0);

    // Non-power-of-2 wrap
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req_d = 3'b111; #2;
      chk($sformatf("t5_idx[%0d]", i), 32'(gi_d), 32'(t5_idx[i]));
    end

    // Async reset mid-burst
    @(negedge clk); req_e = 4'b0100; #2;
    chk("t6_b0", 32'(gi_e), 2);
    @(negedge clk); #2;
    chk("t6_b1", 32'(gi_e), 2);
    chk("t6_b1_own", 32'(own_e), 1);
    @(negedge clk); req_e = 4'b1111; rdy_e = 1'b0; #2;
    chk("t6_pre_idx", 32'(gi_e), 2);
    chk("t6_pre_own", 32'(own_e), 1);
    rst_e = 1'b0; #1;
    chk("t6_rst_idx", 32'(gi_e), 0);
    chk("t6_rst_own", 32'(own_e), 0);
    req_e = '0; #1;
    chk("t6_rst_gnt", 32'(gnt_e), 0);
    chk("t6_rst_gv",  32'(gv_e),  0);
    rst_e = 1'b1; rdy_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req_e = 4'b1100; #2;
      chk($sformatf("t6_idx[%0d]", i), 32'(gi_e), 32'(t6_idx[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_n.md
Name: round_robin_arbiter_n

Overview:
- Parametrised N-requester round-robin arbiter with a ready handshake and an optional bounded burst hold.
- Successor to the 2-request arbiter. Serves shared-resource muxes (bus, memory port, FIFO drain) where a grant must stay stable until the consumer accepts it.
- The grant is a combinational function of requests and registered state, so the winner is visible in the same cycle as its request.

Parameters:
- N, 4, number of requesters; legal range 2..32; need not be a power of two.
- MAX_HOLD, 1, number of consecutive accepted grants one requester may take before rotation is forced; 1 gives pure per-transfer round robin; legal range 1..255.
- IDX_W, $clog2(N), localparam; index width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector; bit i is requester i
- ready  input  1  consumer accepts the current grant this cycle
- grant  output  N  one-hot grant, or zero when nothing is granted
- grant_valid  output  1  equals the OR of grant
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when grant_valid=0
- owned  output  1  a requester currently holds ownership (stall or burst)

Behaviour:
- State: ptr_r (IDX_W bits), own_v_r, own_idx_r (IDX_W bits), hold_cnt_r (8 bits).
- Reset is asynchronous on negedge rst_n: ptr_r=0, own_v_r=0, own_idx_r=0, hold_cnt_r=0.
- Outputs are combinational. Under reset with req=0, all outputs are 0.
- Reset asserted mid-burst or mid-stall drops ownership immediately.
- Accept = grant_valid & ready. ready is ignored when grant_valid=0.
- Winner selection, zero-cycle latency from req to grant:
  - If own_v_r and req[own_idx_r]: the winner is own_idx_r, regardless of ptr_r.
  - Otherwise, rotate: scan from index ptr_r upward, wrapping N-1 to 0. The first set req bit wins.
  - If req=0: grant=0, grant_valid=0, grant_idx=0.
- Ownership release: if own_v_r and req[own_idx_r]=0, ownership is ignored in the same cycle. Rotation picks a winner, and own_v_r clears on the next edge. ptr_r is unchanged by a withdrawal.
- Stall (grant_valid=1, ready=0) at the next edge:
  - own_v_r=1, own_idx_r=winner.
  - hold_cnt_r and ptr_r unchanged.
  - The grant stays stable until the winner is accepted or withdraws its request.
- Accept at the next edge, where cnt_next = hold_cnt_r+1:
  - If cnt_next < MAX_HOLD: own_v_r=1, own_idx_r=winner, hold_cnt_r=cnt_next, ptr_r unchanged (burst continues).
  - Otherwise: own_v_r=0, hold_cnt_r=0, ptr_r=(winner+1) mod N. For a non-power-of-2 N, the wrap uses explicit compare, not truncation.
- Idle (req=0): ptr_r and hold_cnt_r are held. own_v_r clears per the release rule.
- A new requester's request during a burst or stall does not pre-empt the owner.
- With MAX_HOLD=1 and ready tied high, behaviour matches the 2-request arbiter for N=2. Example, with req and grant written bit1..bit0: req 01,00,10,11,11,00,11 gives grant 01,00,10,01,10,00,01.
- Invariants:
  - grant is one-hot or zero.
  - grant is a subset of req.
  - No requester with req held high waits more than (N-1)*MAX_HOLD accepts of others.

Decomposition:
- Shared package rr_arb_pkg holds:
  - function rr_wrap_inc(idx, n) for modulo increment.
  - constant RR_HOLD_CNT_W=8.
  - parameter range checks, via elaboration-time $error, for N and MAX_HOLD.
- Sub-module round_robin_pick is purely combinational, with parameter N:
  - Inputs: req, ptr.
  - Outputs: grant one-hot, idx, valid.
  - Implementation: double-width masked priority search.
- round_robin_arbiter_n holds the registers, ownership override and handshake.

Test Plan:
- N=2, MAX_HOLD=1, ready=1, req sequence 01,00,10,11,11,00,11,00,11,11 -> grant 01,00,10,01,10,00,01,00,10,01.
- N=4, MAX_HOLD=1, ready=1, req=4'b1111 held for 8 cycles -> grant_idx 0,1,2,3,0,1,2,3. Then req=4'b1010 -> grant_idx 1,3,1.
- N=4, req=4'b0110, ready=0 for 3 cycles, then 1 -> grant_idx=1 stable all 4 cycles, owned=1 during the stall. The next cycle gives grant_idx=2.
- N=4, MAX_HOLD=3, ready=1, req=4'b0011 -> grant_idx 0,0,0,1,1,1,0. Then drop req[0] mid-burst -> grant moves to 1 in the same cycle.
- N=3 (non-power-of-2), MAX_HOLD=1, req=3'b111 -> grant_idx 0,1,2,0; ptr_r never reaches 3.
- Burst in progress, N=4, MAX_HOLD=4, owner idx 2, then rst_n pulsed low asynchronously mid-cycle -> outputs follow the rotation from ptr 0 immediately; owned=0; the next grant for req=4'b1100 is idx 2 with a fresh hold count.
